demux_feed_ctrl: RTL and testbench
==================================

# demux_feed_ctrl

Sequencer that drives the 1-to-16 lane demultiplexer in the NPU load path. It accepts a valid/ready stream of DATA_WIDTH-bit words and presents each word with a lane select and a write strobe, stepping lanes 0,1,2,… for a programmed number of lanes per frame. A frame is one start command followed by lane_count accepted words, ending in a one-cycle done pulse. It sits directly upstream of the demux and owns all of its select timing.

## Interface
- DATA_WIDTH, 12, width of each data word and of the demux data path
- NUM_LANES, 16, number of demux outputs; fixed at 16, so the select is 4 bits
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame start pulse; only honoured in IDLE
- lane_count  in  5  lanes per frame, sampled with start; 1..16 legal, 0 or >16 clamped to 16
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts a word this cycle
- in_data  in  DATA_WIDTH  input word
- out_data  out  DATA_WIDTH  word to the demux data input
- out_sel  out  4  lane select to the demux
- out_we  out  1  one-cycle strobe; out_data and out_sel are valid only while it is high
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse marking the end of a frame

## Operation
- States: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE, no skid buffer: in_ready=0.
- IDLE with start=1: latch the clamped lane_count into cnt_q, set idx=0, go to LOAD.
- LOAD: in_ready=1. This is decoded from the registered state, with no combinational path from in_valid.
- LOAD, on each handshake (in_valid & in_ready):
  - register out_data<=in_data, out_sel<=idx, out_we<=1;
  - idx<=idx+1;
  - if idx==cnt_q-1, go to DONE.
- DONE lasts exactly one cycle: done=1, then back to IDLE.
- out_we is 0 in every cycle without a preceding handshake.
- out_data and out_sel hold their last values when out_we=0.
- idx is 5 bits internally and never exceeds 15 at any handshake. out_sel = idx[3:0], so there is no wrap within a frame.
- start is ignored while busy (LOAD or DONE), including the cycle in which done=1.
- in_valid in IDLE (no skid buffer) is not accepted. Data is held upstream by in_ready=0.
- Reset mid-frame: all registers clear immediately and asynchronously, and the partial frame is abandoned. No done is issued.
- Reset values: in_ready=0, out_data=0, out_sel=0, out_we=0, busy=0, done=0.

## Timing
- Handshake in cycle N gives out_we=1 in cycle N+1 (latency 1, no skid buffer).
- The final handshake of a frame in cycle N gives the last out_we and done=1 together in cycle N+1, then IDLE in N+2.
- Earliest next start is the cycle after done (N+2). A frame then becomes busy one cycle after its start.
- Full throughput: one lane per cycle with in_valid held high. A 16-lane frame is 16 consecutive out_we cycles.
- Bubbles on in_valid insert out_we=0 cycles. idx does not advance during bubbles.

## Configuration
- FEED_SKID_EN defined:
  - a two-entry skid buffer sits between the input port and the FSM;
  - in_ready is registered and equals "buffer not full", independent of state;
  - up to 2 words may be accepted while IDLE; they are consumed first by the next frame;
  - latency from input handshake to out_we is 2 cycles;
  - buffered words persist across frames and are cleared only by rst_n.
- FEED_SKID_EN undefined:
  - no buffer;
  - in_ready follows state as described above;
  - latency is 1 cycle.

## Structure
- Shared package npu_pkg holds:
  - DATA_WIDTH default;
  - NUM_LANES;
  - LANE_SEL_W=4;
  - the feed state enum (IDLE/LOAD/DONE);
  - the lane_count clamp constant (16).
- One sub-module, feed_skid: a parameterised 2-entry valid/ready skid buffer. It is instantiated only under FEED_SKID_EN.

## Test plan
- Reset, then start with lane_count=4 and words 0x001..0x004 presented back-to-back:
  - out_we for 4 cycles with sel 0,1,2,3 and data 0x001..0x004;
  - done coincides with sel=3;
  - busy falls the next cycle.
- lane_count=16 with continuous valid: 16 strobes, sel 0..15 in order, then done; no sel beyond 15.
- lane_count=0 and lane_count=20: each is treated as 16 lanes.
- lane_count=3 with in_valid toggling every other cycle: strobes occur only after handshakes, sel 0,1,2; done is one cycle after the third accepted word.
- start asserted during LOAD and on the done cycle: both ignored. A start one cycle after done begins a new frame at sel=0.
- rst_n low after 5 of 8 words: outputs go to 0 immediately and no done is issued. A fresh start after release begins at sel=0.

Source files
------------

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU load-path types and constants
package npu_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int NUM_LANES      = 16;
    localparam int LANE_SEL_W     = 4;
    localparam logic [4:0] LANE_CNT_MAX = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } feed_state_t;

    // A zero or oversized lane count selects a full 16-lane frame.
    function automatic logic [4:0] clamp_lanes(input logic [4:0] lc);
        return ((lc == 5'd0) || (lc > LANE_CNT_MAX)) ? LANE_CNT_MAX : lc;
    endfunction

endpackage

// File: rtl/feed_skid.sv
// rtl/feed_skid.sv - two-entry valid/ready skid buffer with registered ready
module feed_skid #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             push;
    logic             pop;

    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            s_tready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count    <= count_next;
            s_tready <= (count_next != 2'd2);
        end
    end

endmodule

// File: rtl/demux_feed_ctrl.sv
// rtl/demux_feed_ctrl.sv - lane sequencer for the 1-to-16 load demux; FEED_SKID_EN adds an input skid buffer
module demux_feed_ctrl
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4:0]            lane_count,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LANE_SEL_W-1:0] out_sel,
    output logic                  out_we,
    output logic                  busy,
    output logic                  done
);

    feed_state_t           state;
    logic [4:0]            cnt_q;
    logic [4:0]            idx;
    logic [DATA_WIDTH-1:0] fsm_data;
    logic                  fsm_valid;
    logic                  fsm_ready;
    logic                  hs;

    assign fsm_ready = (state == LOAD);
    assign hs        = fsm_valid & fsm_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

`ifdef FEED_SKID_EN
    feed_skid #(.WIDTH(DATA_WIDTH)) u_feed_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (in_data),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .m_tdata  (fsm_data),
        .m_tvalid (fsm_valid),
        .m_tready (fsm_ready)
    );
`else
    assign in_ready  = fsm_ready;
    assign fsm_data  = in_data;
    assign fsm_valid = in_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt_q    <= 5'd0;
            idx      <= 5'd0;
            out_data <= '0;
            out_sel  <= '0;
            out_we   <= 1'b0;
        end else begin
            out_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_q <= clamp_lanes(lane_count);
                        idx   <= 5'd0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        out_data <= fsm_data;
                        out_sel  <= idx[LANE_SEL_W-1:0];
                        out_we   <= 1'b1;
                        idx      <= idx + 5'd1;
                        if (idx == cnt_q - 5'd1)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_feed_ctrl.sv
// tb/tb_demux_feed_ctrl.sv - self-checking bench for demux_feed_ctrl
module tb_demux_feed_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  lane_count = 5'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = 12'd0;
    logic [11:0] out_data;
    logic [3:0]  out_sel;
    logic        out_we;
    logic        busy;
    logic        done;

    demux_feed_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .lane_count (lane_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_we     (out_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame model: words still owed, next lane, and whether the done cycle is showing.
    bit m_load, m_done, e_we;
    int m_left, m_next, e_sel, e_data;
    int log_sel[$];
    int log_data[$];
    int done_cnt;

    task automatic chk(string nm, int got, int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_load = 0; m_done = 0; m_left = 0; m_next = 0;
            e_we = 0; e_sel = 0; e_data = 0;
            return;
        end
        e_we = 0;
        if (m_load && in_valid) begin
            e_we   = 1;
            e_sel  = m_next;
            e_data = int'(in_data);
            m_next++;
            m_left--;
            if (m_left == 0) begin
                m_load = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_load && start) begin
            m_load = 1;
            m_left = (lane_count == 0 || lane_count > 16) ? 16 : int'(lane_count);
            m_next = 0;
        end
    endtask

    task automatic compare();
        chk("in_ready", int'(in_ready), int'(m_load));
        chk("out_we",   int'(out_we),   int'(e_we));
        chk("out_sel",  int'(out_sel),  e_sel);
        chk("out_data", int'(out_data), e_data);
        chk("busy",     int'(busy),     int'(m_load || m_done));
        chk("done",     int'(done),     int'(m_done));
        if (out_we) begin
            log_sel.push_back(int'(out_sel));
            log_data.push_back(int'(out_data));
        end
        if (done) done_cnt++;
    endtask

    task automatic step(bit s, bit v, int d);
        start    = s;
        in_valid = v;
        in_data  = d[11:0];
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic clear_log();
        log_sel.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic chk_seq(string nm, int n);
        chk({nm, "_count"}, log_sel.size(), n);
        if (log_sel.size() == n)
            for (int i = 0; i < n; i++) chk({nm, "_sel"}, log_sel[i], i);
        chk({nm, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        int lcs[2];
        lcs[0] = 0;
        lcs[1] = 20;

        // Reset state
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("rst_out_we", int'(out_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        step(0, 1, 12'h7ff);
        chk("idle_no_accept", int'(out_we), 0);

        // Four lanes back to back
        clear_log();
        lane_count = 5'd4;
        step(1, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, i);
        chk("f4_done", int'(done), 1);
        chk("f4_done_sel", int'(out_sel), 3);
        chk("f4_done_data", int'(out_data), 12'h004);
        step(0, 0, 0);
        chk("f4_busy_fall", int'(busy), 0);
        chk_seq("f4", 4);
        if (log_data.size() == 4)
            for (int i = 0; i < 4; i++) chk("f4_data", log_data[i], i + 1);

        // Sixteen lanes continuous
        clear_log();
        lane_count = 5'd16;
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 12'h100 + i);
        chk_seq("f16", 16);

        // Clamped lane counts
        foreach (lcs[k]) begin
            clear_log();
            lane_count = lcs[k][4:0];
            step(1, 0, 0);
            for (int i = 0; i < 18; i++) step(0, 1, 12'h300 + i);
            chk_seq("clamp", 16);
        end

        // Bubbled input
        clear_log();
        lane_count = 5'd3;
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, (i % 2) == 0, 12'h200 + i);
        chk_seq("bubble", 3);

        // Start during LOAD and on the done cycle is ignored
        clear_log();
        lane_count = 5'd2;
        step(1, 0, 0);
        step(1, 1, 12'h030);
        step(1, 1, 12'h031);
        chk("ign_done", int'(done), 1);
        step(1, 0, 0);
        chk("ign_idle", int'(busy), 0);
        lane_count = 5'd1;
        step(1, 0, 0);
        chk("restart_busy", int'(busy), 1);
        clear_log();
        step(0, 1, 12'h032);
        chk("restart_sel", int'(out_sel), 0);
        chk("restart_data", int'(out_data), 12'h032);
        step(0, 0, 0);

        // Reset mid-frame
        clear_log();
        lane_count = 5'd8;
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 12'h040 + i);
        chk("mid_sel", int'(out_sel), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", int'(out_we), 0);
        chk("mid_rst_sel", int'(out_sel), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        step(0, 1, 12'h099);
        step(0, 1, 12'h099);
        rst_n = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("mid_no_done", done_cnt, 0);
        clear_log();
        lane_count = 5'd2;
        step(1, 0, 0);
        step(0, 1, 12'h050);
        step(0, 1, 12'h051);
        step(0, 0, 0);
        chk_seq("post_rst", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
